// File: rtl/upordown_counter_pkg.sv
// Shared constants for the up/down counter: default width and direction encodings.
package upordown_counter_pkg;
   localparam int   WIDTH_DEFAULT = 4;
   localparam logic DIR_UP        = 1'b1;
   localparam logic DIR_DOWN      = 1'b0;
endpackage

// File: rtl/upordown_counter_next.sv
// Next-value logic for the up/down counter; purely combinational, modulo 2^WIDTH.
// An unknown direction falls through to the count-down path.
module upordown_counter_next
   import upordown_counter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
)(
   input  logic [WIDTH-1:0] cur,
   input  logic             dir,
   output logic [WIDTH-1:0] nxt
);

   always_comb begin
      nxt = cur - WIDTH'(1);
      if (dir == DIR_UP)
         nxt = cur + WIDTH'(1);
   end

endmodule

// File: rtl/upordown_counter.sv
// Free-running up/down counter, one step per Clk edge, Count straight from the register.
// No enable or backpressure; active-low reset clears Count immediately.
module upordown_counter
   import upordown_counter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
)(
   input  logic             Clk,
   input  logic             reset,
   input  logic             UpOrDown,
   output logic [WIDTH-1:0] Count
);

   logic [WIDTH-1:0] count_nxt;

   upordown_counter_next #(.WIDTH(WIDTH)) u_next (
      .cur (Count),
      .dir (UpOrDown),
      .nxt (count_nxt)
   );

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset)
         Count <= '0;
      else
         Count <= count_nxt;
   end

endmodule

// File: tb/tb_upordown_counter.sv
// Randomised scoreboard bench for upordown_counter at WIDTH=4 and WIDTH=2 side by side.
module tb_upordown_counter;
   import upordown_counter_pkg::*;

   logic       Clk;
   logic       reset;
   logic       UpOrDown;
   logic [3:0] count4;
   logic [1:0] count2;

   upordown_counter #(.WIDTH(4)) dut4 (
      .Clk      (Clk),
      .reset    (reset),
      .UpOrDown (UpOrDown),
      .Count    (count4)
   );

   upordown_counter #(.WIDTH(2)) dut2 (
      .Clk      (Clk),
      .reset    (reset),
      .UpOrDown (UpOrDown),
      .Count    (count2)
   );

   // Rising edges at 15, 35, 55, ... ns; period 20 ns.
   initial begin
      Clk = 1'b0;
      #5;
      forever #10 Clk = ~Clk;
   end

   typedef struct {
      int    e4;
      int    e2;
      string tag;
   } exp_t;

   exp_t sb[$];
   event chk_ev;
   int   total = 0;
   int   bad   = 0;

   // Reference model: value modulo 2^W, stepped once per edge while out of reset.
   int   m4 = 0;
   int   m2 = 0;
   bit   rst_m = 1'b0;

   function automatic int step_mod(input int v, input logic d, input int modulus);
      int delta;
      delta = (d === 1'b1) ? 1 : modulus - 1;
      return (v + delta) % modulus;
   endfunction

   task automatic push_exp(input string tag);
      exp_t e;
      e.e4  = m4;
      e.e2  = m2;
      e.tag = tag;
      sb.push_back(e);
   endtask

   // Apply direction mid-cycle, take one edge, record expectation, settle past the negedge.
   task automatic edge_step(input logic d, input string tag);
      UpOrDown = d;
      @(posedge Clk);
      if (rst_m) begin
         m4 = step_mod(m4, d, 16);
         m2 = step_mod(m2, d, 4);
      end
      push_exp(tag);
      #12;
   endtask

   task automatic assert_rst(input string tag);
      reset = 1'b0;
      rst_m = 1'b0;
      m4    = 0;
      m2    = 0;
      #1;
      push_exp(tag);
      -> chk_ev;
   endtask

   task automatic release_mid();
      reset = 1'b1;
      rst_m = 1'b1;
   endtask

   // Release lands on the edge itself; the non-blocking update makes the
   // register see reset still asserted on that edge, as the design intends.
   task automatic release_at_edge(input string tag);
      UpOrDown = DIR_UP;
      @(posedge Clk);
      reset <= 1'b1;
      push_exp(tag);
      rst_m = 1'b1;
      #12;
   endtask

   // Monitor: checks one expectation per falling edge, or immediately on an async event.
   initial begin
      exp_t e;
      forever begin
         @(negedge Clk or chk_ev);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if (count4 !== 4'(e.e4)) begin
               bad++;
               $display("FAIL %s w4: got %0d expected %0d at %0t", e.tag, count4, e.e4, $time);
            end
            total++;
            if (count2 !== 2'(e.e2)) begin
               bad++;
               $display("FAIL %s w2: got %0d expected %0d at %0t", e.tag, count2, e.e2, $time);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, time %0t limit 100000", $time);
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

   initial begin
      int r;
      reset    = 1'b0;
      UpOrDown = DIR_UP;
      #2;
      push_exp("por");
      -> chk_ev;
      #8;
      release_mid();
      #1;
      push_exp("release_hold");
      -> chk_ev;

      for (int i = 0; i < 16; i++) edge_step(DIR_UP, "up_wrap");
      for (int i = 0; i < 3; i++)  edge_step(DIR_UP, "up_to_3");
      for (int i = 0; i < 5; i++)  edge_step(DIR_DOWN, "down_wrap");
      for (int i = 0; i < 11; i++) edge_step(DIR_UP, "up_to_9");

      assert_rst("mid_reset");
      for (int i = 0; i < 3; i++) edge_step(logic'(i[0]), "reset_hold");

      release_at_edge("release_on_edge");
      edge_step(DIR_UP, "after_edge_release");

      assert_rst("reset_again");
      edge_step(DIR_DOWN, "reset_hold2");
      release_mid();
      for (int i = 0; i < 5; i++) edge_step(DIR_DOWN, "down_from_reset");

      for (int i = 0; i < 300; i++) begin
         r = int'($urandom_range(0, 19));
         if (r == 0 && rst_m)
            assert_rst("rand_reset");
         else if (r == 1 && !rst_m)
            release_mid();
         else if (r == 2 && !rst_m)
            release_at_edge("rand_edge_release");
         else
            edge_step(logic'($urandom_range(0, 1)), "random");
      end
      if (!rst_m) release_mid();
      for (int i = 0; i < 4; i++) edge_step(logic'($urandom_range(0, 1)), "tail");

      @(negedge Clk);
      #1;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/upordown_counter.md
UPORDOWN_COUNTER -- requirements
Module: upordown_counter

Interface
REQ-001 Parameter: WIDTH, default 4, counter width in bits (legal range 1..32).
REQ-002 Port: Clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 Port: UpOrDown  input  1  direction select; 1 = count up, 0 = count down.
REQ-005 Port: Count  output  WIDTH  current counter value, driven directly from a register.
REQ-006 One clock; reset is asynchronous and active-low; no other ports.

Function
REQ-007 While reset is high, each rising Clk edge SHALL update Count: UpOrDown=1 -> Count+1; UpOrDown=0 -> Count-1.
REQ-008 UpOrDown SHALL be sampled only at the rising Clk edge; a change between edges SHALL take effect at the next edge.
REQ-009 Latency: Count SHALL reflect each update in the same cycle as the edge that caused it; there is no pipeline stage.
REQ-010 Arithmetic SHALL be unsigned modulo 2^WIDTH.
REQ-011 Up wrap: at 2^WIDTH-1, the counter SHALL wrap to 0 (4'b1111 -> 4'b0000).
REQ-012 Down wrap: at 0, the counter SHALL wrap to 2^WIDTH-1 (4'b0000 -> 4'b1111).
REQ-013 There is no enable and no hold state; every clock edge outside reset SHALL change Count by exactly one.
REQ-014 A direction change SHALL take effect on the first edge after it, with no dead cycle and no skipped value.
REQ-015 Count SHALL never be X/Z after the first reset assertion.
REQ-016 If UpOrDown is X/Z at a sampled edge, the counter SHALL treat it as 0 (count down).

Reset
REQ-017 reset=0 SHALL force Count to 0 immediately, independent of Clk.
REQ-018 While reset=0, Count SHALL hold 0 regardless of Clk and UpOrDown.
REQ-019 Reset mid-count (any value, either direction) SHALL clear Count to 0 with no further update until release.
REQ-020 On reset release (0->1), the first count update SHALL occur at the next rising Clk edge.
REQ-021 If release coincides with a rising edge, that edge SHALL NOT update Count; counting starts at the following edge.

Structure
REQ-022 A shared package upordown_counter_pkg SHALL hold the WIDTH default (4) and direction constants DIR_UP=1'b1 and DIR_DOWN=1'b0.
REQ-023 A combinational sub-module upordown_counter_next SHALL compute the next value from the current value and the direction.
REQ-024 The top level SHALL contain only the asynchronous-reset state register and the sub-module instance.
REQ-025 The design SHALL contain no latches, no gated clocks and no initial-value dependence.

Verification
REQ-026 Power-up with reset=0 for 10 ns, then released with Clk period 20 ns -> Count=0 until the first edge after release.
REQ-027 Release reset with UpOrDown=1 for 16 edges -> Count 1,2,...,15,0 (up wrap verified).
REQ-028 From Count=3, set UpOrDown=0 -> Count 2,1,0,15,14 (down wrap verified, no dead cycle).
REQ-029 Assert reset mid-cycle (between edges) while Count=9 -> Count=0 immediately; holds 0 across 3 edges while toggling UpOrDown.
REQ-030 Release reset at the same time as a rising edge with UpOrDown=1 -> Count stays 0 on that edge and is 1 on the next.
REQ-031 WIDTH=2, UpOrDown=0 from reset -> Count 3,2,1,0,3 on successive edges.
